dram_responder: RTL and testbench

- Synthesizable device-side model of a multiplexed-address asynchronous DRAM chip. It answers the same /RAS, /CAS, /OE, /WE, address and data pins that the FPGA DRAM controller drives.
- Backs the array with an external synchronous RAM port. Used for on-FPGA loopback builds and as the bench target for the controller and arbiter.
- Decodes row/column latching, page-mode accesses and /CAS-before-/RAS refresh.
- Provides a refresh-retention watchdog and a protocol-error flag.

---
 rtl/dram_responder.sv | 150 +++++++++++++++
 tb/tb_dram_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// Device-side model of a multiplexed-address async DRAM, backed by a synchronous RAM port.
// Array ops issue on the CAS-fall cycle; read data drives dramData one cycle later. No backpressure.
module dram_responder #(
  parameter int ROW_WIDTH       = 8,
  parameter int COL_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int REFRESH_TIMEOUT = 512,
  parameter int REF_COUNT_WIDTH = 16,
  localparam int ADDR_WIDTH     = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           nDRAMRead,
  input  logic                           nDRAMWrite,
  input  logic                           nDRAMRAS,
  input  logic                           nDRAMCAS,
  input  logic [ADDR_WIDTH-1:0]          dramAddr,
  inout  wire  [DATA_WIDTH-1:0]          dramData,
  output logic [ROW_WIDTH+COL_WIDTH-1:0] memAddr,
  output logic                           memRead,
  output logic                           memWrite,
  output logic [DATA_WIDTH-1:0]          memWData,
  input  logic [DATA_WIDTH-1:0]          memRData,
  output logic [REF_COUNT_WIDTH-1:0]     refreshCount,
  output logic                           refreshMissed,
  output logic                           protocolError,
  input  logic                           errorClear
);

  localparam int WD_WIDTH = $clog2(REFRESH_TIMEOUT + 1);
  localparam logic [WD_WIDTH-1:0] WD_MAX = WD_WIDTH'(REFRESH_TIMEOUT);
  localparam logic [WD_WIDTH-1:0] WD_PRE = WD_WIDTH'(REFRESH_TIMEOUT - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ROW      = 3'd1;
  localparam logic [2:0] ACCESS   = 3'd2;
  localparam logic [2:0] CBR_PEND = 3'd3;
  localparam logic [2:0] CBR_ACT  = 3'd4;

  logic [2:0]           state;
  logic                 prevRAS, prevCAS, prevWE;
  logic [ROW_WIDTH-1:0] rowReg;
  logic                 readValid;
  logic [WD_WIDTH-1:0]  watchdog;

  logic rasFall, rasRise, casFall, casRise, weFall;
  logic colAccess, readStrobe, writeStrobe, refreshEvent, protoErr, driveEn;

  // Pins share clk with the controller, so edges are detected on the live values.
  assign rasFall = ~nDRAMRAS & prevRAS;
  assign rasRise = nDRAMRAS & ~prevRAS;
  assign casFall = ~nDRAMCAS & prevCAS;
  assign casRise = nDRAMCAS & ~prevCAS;
  assign weFall  = ~nDRAMWrite & prevWE;

  assign colAccess    = (state == ROW) & casFall & ~nDRAMRAS & ~reset;
  assign readStrobe   = colAccess & ~nDRAMRead & nDRAMWrite;
  assign writeStrobe  = colAccess & ~nDRAMWrite & nDRAMRead;
  assign refreshEvent = (state == CBR_PEND) & rasFall;

  assign protoErr = ((state == IDLE) & rasFall & casFall)
                  | (colAccess & ~nDRAMRead & ~nDRAMWrite)
                  | ((state == ACCESS) & weFall & ~nDRAMCAS)
                  | ((state == CBR_PEND) & casRise & ~rasFall);

  assign memAddr  = {dramAddr[COL_WIDTH-1:0], rowReg};
  assign memRead  = readStrobe;
  assign memWrite = writeStrobe;
  assign memWData = writeStrobe ? dramData : '0;

  // RAS high releases the bus immediately, even if CAS is still low.
  assign driveEn  = readValid & (state == ACCESS) & ~nDRAMCAS & ~nDRAMRead & ~nDRAMRAS;
  assign dramData = driveEn ? memRData : 'z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prevRAS   <= 1'b1;
      prevCAS   <= 1'b1;
      prevWE    <= 1'b1;
      rowReg    <= '0;
      readValid <= 1'b0;
    end else begin
      prevRAS <= nDRAMRAS;
      prevCAS <= nDRAMCAS;
      prevWE  <= nDRAMWrite;
      case (state)
        IDLE: begin
          if (rasFall & casFall) begin
            state <= IDLE;
          end else if (rasFall & nDRAMCAS) begin
            rowReg <= dramAddr[ROW_WIDTH-1:0];
            state  <= ROW;
          end else if (casFall & nDRAMRAS) begin
            state <= CBR_PEND;
          end
        end
        ROW: begin
          if (rasRise) begin
            state <= IDLE;
          end else if (casFall) begin
            state     <= ACCESS;
            readValid <= readStrobe;
          end
        end
        ACCESS: begin
          if (rasRise) begin
            state     <= IDLE;
            readValid <= 1'b0;
          end else if (casRise) begin
            state     <= ROW;
            readValid <= 1'b0;
          end
        end
        CBR_PEND: begin
          if (rasFall)      state <= CBR_ACT;
          else if (casRise) state <= IDLE;
        end
        CBR_ACT: begin
          if (nDRAMRAS & nDRAMCAS) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A refresh landing on the timeout cycle resets the watchdog and suppresses the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refreshCount  <= '0;
      watchdog      <= '0;
      refreshMissed <= 1'b0;
      protocolError <= 1'b0;
    end else begin
      if (refreshEvent) begin
        refreshCount <= refreshCount + 1'b1;
        watchdog     <= '0;
      end else if (watchdog != WD_MAX) begin
        watchdog <= watchdog + 1'b1;
      end

      if (~refreshEvent & (watchdog == WD_PRE)) refreshMissed <= 1'b1;
      else if (errorClear)                     refreshMissed <= 1'b0;

      if (protoErr)        protocolError <= 1'b1;
      else if (errorClear) protocolError <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: pin-level vectors with an array-op scoreboard, plus
// hand-written sequences for errors, refresh, watchdog and mid-access reset.
module tb_dram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        nDRAMRead, nDRAMWrite, nDRAMRAS, nDRAMCAS;
  logic [7:0]  dramAddr;
  wire  [7:0]  dramData;
  logic        tbEn;
  logic [7:0]  tbDrv;
  logic [15:0] memAddr;
  logic        memRead, memWrite;
  logic [7:0]  memWData;
  logic [7:0]  memRData;
  logic [15:0] refreshCount;
  logic        refreshMissed, protocolError, errorClear;

  int nCmp;
  int nErr;

  typedef struct {
    logic [1:0]  op;    // 0 none, 1 read, 2 write
    logic [15:0] addr;
    logic [7:0]  data;
  } op_t;
  op_t expQ[$];

  typedef struct {
    logic        r, c, o, w;
    logic [7:0]  a;
    logic        drv;
    logic [7:0]  wd;
    logic [1:0]  op;
    logic [15:0] ma;
    logic        rel;
    logic [7:0]  d;
  } vec_t;
  vec_t vecs[$];

  // External synchronous RAM; unwritten locations return a nonzero address pattern.
  bit [7:0] mem     [0:65535];
  bit       written [0:65535];

  function automatic logic [7:0] initVal(input logic [15:0] a);
    return 8'h80 | {1'b0, a[14:8] ^ a[6:0]};
  endfunction

  always @(posedge clk) begin
    if (memWrite) begin
      mem[memAddr]     <= memWData;
      written[memAddr] <= 1'b1;
    end
    if (memRead) memRData <= written[memAddr] ? mem[memAddr] : initVal(memAddr);
  end

  assign dramData = tbEn ? tbDrv : 'z;
  always #5 clk = ~clk;

  dram_responder dut (
    .clk(clk), .reset(reset),
    .nDRAMRead(nDRAMRead), .nDRAMWrite(nDRAMWrite), .nDRAMRAS(nDRAMRAS), .nDRAMCAS(nDRAMCAS),
    .dramAddr(dramAddr), .dramData(dramData),
    .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite), .memWData(memWData), .memRData(memRData),
    .refreshCount(refreshCount), .refreshMissed(refreshMissed), .protocolError(protocolError),
    .errorClear(errorClear)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkRel(input string nm);
    nCmp++;
    if (!(dramData === 8'hzz || dramData === 8'h00)) begin
      nErr++;
      $display("FAIL %s: dramData %0h expected released", nm, dramData);
    end
  endtask

  task automatic sbCheck();
    op_t e;
    logic [1:0] aop;
    if (memRead || memWrite) begin
      chk("one_op_per_cycle", {31'b0, memRead & memWrite}, 32'd0);
      aop = memWrite ? 2'd2 : 2'd1;
      if (expQ.size() == 0) begin
        nCmp++;
        nErr++;
        $display("FAIL unexpected_op: op %0d addr %0h, expected none", aop, memAddr);
      end else begin
        e = expQ.pop_front();
        chk("sb_op", {30'b0, aop}, {30'b0, e.op});
        chk("sb_addr", {16'b0, memAddr}, {16'b0, e.addr});
        if (e.op == 2'd2) chk("sb_wdata", {24'b0, memWData}, {24'b0, e.data});
      end
    end
  endtask

  task automatic pins(input logic r, input logic c, input logic o, input logic w, input logic [7:0] a);
    nDRAMRAS = r; nDRAMCAS = c; nDRAMRead = o; nDRAMWrite = w; dramAddr = a;
  endtask

  task automatic halfToNeg();
    @(negedge clk);
    sbCheck();
  endtask

  task automatic toPos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    halfToNeg();
    toPos();
  endtask

  task automatic doReset();
    reset = 1'b1; tbEn = 1'b0; errorClear = 1'b0;
    pins(1, 1, 1, 1, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pushOp(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
    op_t e;
    e.op = op; e.addr = a; e.data = d;
    expQ.push_back(e);
  endtask

  function automatic vec_t mk(input logic r, input logic c, input logic o, input logic w,
                              input logic [7:0] a, input logic drv, input logic [7:0] wd,
                              input logic [1:0] op, input logic [15:0] ma,
                              input logic rel, input logic [7:0] d);
    vec_t v;
    v.r = r; v.c = c; v.o = o; v.w = w; v.a = a; v.drv = drv; v.wd = wd;
    v.op = op; v.ma = ma; v.rel = rel; v.d = d;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    nCmp = 0; nErr = 0;
    tbEn = 1'b0; tbDrv = 8'h00; errorClear = 1'b0; reset = 1'b0;
    pins(1, 1, 1, 1, 8'h00);
    doReset();

    chk("rst_refreshCount", {16'b0, refreshCount}, 32'd0);
    chk("rst_refreshMissed", {31'b0, refreshMissed}, 32'd0);
    chk("rst_protocolError", {31'b0, protocolError}, 32'd0);
    chk("rst_memRead", {31'b0, memRead}, 32'd0);
    chk("rst_memWrite", {31'b0, memWrite}, 32'd0);
    chk("rst_memWData", {24'b0, memWData}, 32'd0);
    chkRel("rst_dramData");

    // Write 0xA5 at row 0x12 col 0x34, read it back, then a three-column page read of row 0x01.
    vecs.push_back(mk(1, 1, 1, 1, 8'h00, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 8'h12, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(0, 0, 1, 0, 8'h34, 1, 8'hA5, 2, 16'h3412, 1, 8'h00));
    vecs.push_back(mk(0, 0, 1, 0, 8'h34, 1, 8'hA5, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 8'h34, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(1, 1, 1, 1, 8'h00, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 8'h12, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h34, 0, 8'h00, 1, 16'h3412, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h34, 0, 8'h00, 0, 16'h0000, 0, 8'hA5));
    vecs.push_back(mk(0, 1, 1, 1, 8'h34, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(1, 1, 1, 1, 8'h00, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 8'h01, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 1, 16'h0001, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 16'h0000, 0, initVal(16'h0001)));
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h01, 0, 8'h00, 1, 16'h0101, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h01, 0, 8'h00, 0, 16'h0000, 0, initVal(16'h0101)));
    vecs.push_back(mk(0, 1, 1, 1, 8'h01, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h02, 0, 8'h00, 1, 16'h0201, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h02, 0, 8'h00, 0, 16'h0000, 0, initVal(16'h0201)));
    vecs.push_back(mk(1, 0, 0, 1, 8'h02, 0, 8'h00, 0, 16'h0000, 1, 8'h00));
    vecs.push_back(mk(1, 1, 1, 1, 8'h00, 0, 8'h00, 0, 16'h0000, 1, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      pins(v.r, v.c, v.o, v.w, v.a);
      tbEn = v.drv; tbDrv = v.wd;
      if (v.op != 2'd0) pushOp(v.op, v.ma, v.wd);
      halfToNeg();
      if (!v.drv) begin
        if (v.rel) chkRel($sformatf("vec%0d_released", i));
        else       chk($sformatf("vec%0d_rdata", i), {24'b0, dramData}, {24'b0, v.d});
      end
      toPos();
    end
    tbEn = 1'b0;
    chk("pe_after_normal", {31'b0, protocolError}, 32'd0);

    // Both strobes low at CAS fall.
    pins(0, 1, 1, 1, 8'h20); tick();
    pins(0, 0, 0, 0, 8'h05);
    halfToNeg();
    chk("both_strobes_memWrite", {31'b0, memWrite}, 32'd0);
    chk("both_strobes_memRead", {31'b0, memRead}, 32'd0);
    chkRel("both_strobes_bus");
    toPos();
    chk("pe_both_strobes", {31'b0, protocolError}, 32'd1);
    halfToNeg(); chkRel("both_strobes_bus_access"); toPos();
    pins(0, 1, 1, 1, 8'h00); tick();
    pins(1, 1, 1, 1, 8'h00); tick();
    chk("pe_sticky", {31'b0, protocolError}, 32'd1);
    errorClear = 1'b1; tick(); errorClear = 1'b0;
    chk("pe_cleared", {31'b0, protocolError}, 32'd0);

    // Neither strobe at CAS fall is legal; /WE falling afterwards is a late write.
    pins(0, 1, 1, 1, 8'h20); tick();
    pins(0, 0, 1, 1, 8'h05); tick();
    chk("pe_no_strobe", {31'b0, protocolError}, 32'd0);
    pins(0, 0, 1, 0, 8'h05); tbEn = 1'b1; tbDrv = 8'h66; tick(); tbEn = 1'b0;
    chk("pe_late_write", {31'b0, protocolError}, 32'd1);
    pins(0, 1, 1, 1, 8'h00); tick();
    pins(1, 1, 1, 1, 8'h00); tick();
    errorClear = 1'b1; tick(); errorClear = 1'b0;

    // CAS rise in CBR_PEND, coinciding with errorClear: the error wins.
    pins(1, 0, 1, 1, 8'h00); tick();
    pins(1, 1, 1, 1, 8'h00); errorClear = 1'b1; tick(); errorClear = 1'b0;
    chk("pe_cbr_cas_rise_wins_clear", {31'b0, protocolError}, 32'd1);
    chk("rc_no_refresh", {16'b0, refreshCount}, 32'd0);
    errorClear = 1'b1; tick(); errorClear = 1'b0;

    // RAS and CAS falling together from IDLE.
    pins(0, 0, 1, 1, 8'h33); tick();
    chk("pe_ras_cas_same", {31'b0, protocolError}, 32'd1);
    pins(1, 1, 1, 1, 8'h00); tick();
    errorClear = 1'b1; tick(); errorClear = 1'b0;
    chk("pe_clear2", {31'b0, protocolError}, 32'd0);

    // Watchdog with no refresh after reset.
    doReset();
    repeat (511) tick();
    chk("wd_511_missed", {31'b0, refreshMissed}, 32'd0);
    tick();
    chk("wd_512_missed", {31'b0, refreshMissed}, 32'd1);
    repeat (20) tick();
    chk("wd_sticky", {31'b0, refreshMissed}, 32'd1);
    errorClear = 1'b1; tick(); errorClear = 1'b0;
    chk("wd_cleared", {31'b0, refreshMissed}, 32'd0);
    repeat (5) tick();
    chk("wd_stays_clear", {31'b0, refreshMissed}, 32'd0);

    // CBR refresh landing exactly on cycle 512.
    doReset();
    repeat (510) tick();
    pins(1, 0, 1, 1, 8'h00); tick();
    pins(0, 0, 1, 1, 8'hAA); tick();
    chk("cbr_refreshCount", {16'b0, refreshCount}, 32'd1);
    chk("cbr_missed_refresh_wins", {31'b0, refreshMissed}, 32'd0);
    chk("cbr_watchdog", {22'b0, dut.watchdog}, 32'd0);
    repeat (2) tick();
    pins(1, 1, 1, 1, 8'h00); tick();
    chk("cbr_pe", {31'b0, protocolError}, 32'd0);
    repeat (508) tick();
    chk("wd_after_refresh_511", {31'b0, refreshMissed}, 32'd0);
    tick();
    chk("wd_after_refresh_512", {31'b0, refreshMissed}, 32'd1);
    chk("cbr_count_hold", {16'b0, refreshCount}, 32'd1);
    errorClear = 1'b1; tick(); errorClear = 1'b0;

    // Asynchronous reset while a read is driving the bus.
    pins(0, 1, 1, 1, 8'h12); tick();
    pins(0, 0, 0, 1, 8'h34); pushOp(2'd1, 16'h3412, 8'h00); tick();
    halfToNeg();
    chk("pre_reset_read", {24'b0, dramData}, 32'h0000_00A5);
    #2 reset = 1'b1;
    #1;
    chkRel("reset_async_release");
    chk("reset_state_idle", {29'b0, dut.state}, 32'd0);
    chk("reset_refreshCount", {16'b0, refreshCount}, 32'd0);
    chk("reset_memWrite", {31'b0, memWrite}, 32'd0);
    @(posedge clk);
    #1;
    pins(1, 1, 1, 1, 8'h00);
    reset = 1'b0;
    tick();
    pins(0, 1, 1, 1, 8'h56); tick();
    pins(0, 0, 1, 0, 8'h78); tbEn = 1'b1; tbDrv = 8'h3C; pushOp(2'd2, 16'h7856, 8'h3C); tick();
    tbEn = 1'b0;
    pins(0, 1, 1, 1, 8'h00); tick();
    pins(1, 1, 1, 1, 8'h00); tick();
    pins(0, 1, 1, 1, 8'h56); tick();
    pins(0, 0, 0, 1, 8'h78); pushOp(2'd1, 16'h7856, 8'h00); tick();
    halfToNeg();
    chk("post_reset_readback", {24'b0, dramData}, 32'h0000_003C);
    toPos();
    pins(0, 1, 1, 1, 8'h00); tick();
    pins(1, 1, 1, 1, 8'h00); tick();

    chk("sb_drained", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
